t05_least_finder: RTL and testbench
===================================

T05_LEAST_FINDER -- requirements
Module: t05_least_finder

Interface
REQ-001 SHALL have parameter CHARS, default 256, number of character-count entries scanned (1..256).
REQ-002 SHALL have port clk  input  1  system clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port FL_en  input  1  scan enable; high starts a scan and holds the result.
REQ-005 SHALL have port nodeCount  input  7  number of tree nodes already built (from the tree-builder node counter).
REQ-006 SHALL have port rd_req  output  1  memory read request.
REQ-007 SHALL have port rd_addr  output  9  read address; {0,char[7:0]} for a character, {1,0,idx[6:0]} for a node.
REQ-008 SHALL have port rd_valid  input  1  read acknowledge; rd_data is valid in the same cycle.
REQ-009 SHALL have port rd_data  input  46  count or node sum read back; 0 means empty or nulled.
REQ-010 SHALL have ports least1, least2  output  9  smallest and second-smallest entry IDs, encoded as rd_addr; the invalid ID is 9'h180.
REQ-011 SHALL have port sum  output  46  value(least1)+value(least2).
REQ-012 SHALL have port FL_done  output  1  result valid.
REQ-013 SHALL have port ERROR  output  1  read timeout flag.

Function
REQ-014 SHALL implement states IDLE, READ, CMP, DONE.
REQ-015 IDLE: when FL_en=1, SHALL set idx=0, clear both minima to invalid, and go to READ.
REQ-016 READ: SHALL hold rd_req=1 with a stable rd_addr; when rd_valid=1, SHALL capture rd_data and go to CMP. Otherwise it stays in READ.
REQ-017 Scan order SHALL be characters 0..CHARS-1, then nodes 0..nodeCount-1; when nodeCount=0, the node phase is skipped.
REQ-018 CMP: a zero value SHALL be ignored.
REQ-019 CMP: a value v < min1 SHALL shift min1 into min2 and place the new entry in min1.
REQ-020 CMP: otherwise, a value v < min2 SHALL replace min2.
REQ-021 Comparisons SHALL be strict, so on a tie the earlier-scanned entry wins.
REQ-022 CMP SHALL go to READ for the next entry, or to DONE after the last entry.
REQ-023 Each entry SHALL take 1 CMP cycle plus the READ cycles; minimum 2 cycles per entry.
REQ-024 DONE, with at least two valid entries: least1/least2 SHALL be the IDs of min1/min2, and sum SHALL be min1+min2 modulo 2^46.
REQ-025 DONE, with exactly one valid entry: least1 SHALL be its ID, least2 SHALL be 9'h180, and sum SHALL be 0 (tree complete).
REQ-026 DONE, with no valid entry: least1=0, least2=9'h180, sum=0.
REQ-027 Outputs SHALL be registered and FL_done=1 from the cycle after the final CMP; the block holds in DONE while FL_en=1.
REQ-028 FL_en=0 in any state SHALL return the block to IDLE on the next edge, with FL_done=0 and rd_req=0; least1/least2/sum keep their last values.
REQ-029 A new scan SHALL require FL_en to return low and then high again.
REQ-030 A change of nodeCount during a scan SHALL be ignored; the value is sampled in IDLE at scan start.

Reset
REQ-031 While rst_n=0, the block SHALL be in IDLE with rd_req=0, rd_addr=0, least1=0, least2=9'h180, sum=0, FL_done=0, ERROR=0.
REQ-032 Reset mid-scan SHALL abort the scan immediately; no partial result is presented.

Configuration
REQ-033 With T05_FL_TIMEOUT_EN defined, an 8-bit counter SHALL count cycles in READ.
REQ-034 With T05_FL_TIMEOUT_EN defined, 255 cycles without rd_valid SHALL set ERROR=1 (sticky until IDLE) and force DONE with the minima found so far.
REQ-035 Without T05_FL_TIMEOUT_EN, READ SHALL wait indefinitely and ERROR SHALL be tied to 0.

Verification
REQ-036 CHARS=4, counts {5,0,3,7}, nodeCount=0, rd_valid every cycle -> least1=9'h002, least2=9'h000, sum=8, FL_done 8 cycles after FL_en.
REQ-037 Counts {4,4,4,0}, nodeCount=1 with node0=4 -> least1=9'h000, least2=9'h001, sum=8 (tie goes to the earlier entry).
REQ-038 All counts 0 except char 9=12 -> least1=9'h009, least2=9'h180, sum=0.
REQ-039 FL_en dropped during READ of entry 2 -> rd_req=0 and FL_done=0 on the next cycle; re-asserting FL_en restarts from entry 0.
REQ-040 Two node sums of 46'h3FFF_FFFF_FFFF -> sum=46'h3FFF_FFFF_FFFE (wrap modulo 2^46).
REQ-041 With T05_FL_TIMEOUT_EN, rd_valid held at 0 -> ERROR=1 and FL_done=1 after 255 READ cycles; rst_n low clears both.

Source files
------------

// File: rtl/t05_least_finder.sv
// t05_least_finder: scans character counts then tree nodes for the two smallest nonzero entries.
// Define T05_FL_TIMEOUT_EN to abort a READ that waits 255 cycles without rd_valid.
module t05_least_finder #(
  parameter int CHARS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        FL_en,
  input  logic [6:0]  nodeCount,
  output logic        rd_req,
  output logic [8:0]  rd_addr,
  input  logic        rd_valid,
  input  logic [45:0] rd_data,
  output logic [8:0]  least1,
  output logic [8:0]  least2,
  output logic [45:0] sum,
  output logic        FL_done,
  output logic        ERROR
);
  typedef enum logic [1:0] {IDLE, READ, CMP, DONE} state_t;
  localparam logic [7:0] LAST_CHAR = 8'(CHARS - 1);
  localparam logic [8:0] NO_ID = 9'h180;
  state_t r_state, w_next;
  logic [7:0] r_cnt;
  logic r_node, r_v1, r_v2;
  logic [6:0] r_nc;
  logic [45:0] r_data, r_m1, r_m2, w_m1, w_m2;
  logic [8:0] r_id1, r_id2, w_id1, w_id2, w_addr;
  logic w_v1, w_v2, w_last, w_to, w_wrap;
  assign w_addr = r_node ? {2'b10, r_cnt[6:0]} : {1'b0, r_cnt};
  assign w_wrap = !r_node && r_cnt == LAST_CHAR;
  assign w_last = r_node ? (r_cnt[6:0] == r_nc - 7'd1) : (w_wrap && r_nc == 7'd0);
`ifdef T05_FL_TIMEOUT_EN
  logic [7:0] r_to;
  logic r_err;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_to  <= '0;
      r_err <= 1'b0;
    end else begin
      r_to  <= (r_state == READ) ? r_to + 8'd1 : 8'd0;
      r_err <= (w_next == IDLE) ? 1'b0 : (r_err | w_to);
    end
  assign w_to  = r_state == READ && !rd_valid && r_to == 8'd254;
  assign ERROR = r_err;
`else
  assign w_to  = 1'b0;
  assign ERROR = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = FL_en ? READ : IDLE;
      READ:    w_next = !FL_en ? IDLE : rd_valid ? CMP : w_to ? DONE : READ;
      CMP:     w_next = !FL_en ? IDLE : w_last ? DONE : READ;
      default: w_next = FL_en ? DONE : IDLE;
    endcase
  end
  always_comb begin
    rd_req  = r_state == READ;
    rd_addr = rd_req ? w_addr : '0;
  end
  // strict compares keep the earlier-scanned entry on ties
  always_comb begin
    w_m1 = r_m1;
    w_m2 = r_m2;
    w_id1 = r_id1;
    w_id2 = r_id2;
    w_v1 = r_v1;
    w_v2 = r_v2;
    if (r_state == CMP && r_data != '0) begin
      if (!r_v1 || r_data < r_m1) begin
        w_m1 = r_data;
        w_id1 = w_addr;
        w_v1 = 1'b1;
        w_m2 = r_m1;
        w_id2 = r_id1;
        w_v2 = r_v1;
      end else if (!r_v2 || r_data < r_m2) begin
        w_m2 = r_data;
        w_id2 = w_addr;
        w_v2 = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_node <= 1'b0;
      r_nc <= '0;
      r_data <= '0;
      r_m1 <= '0;
      r_m2 <= '0;
      r_id1 <= '0;
      r_id2 <= '0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      least1 <= '0;
      least2 <= NO_ID;
      sum <= '0;
      FL_done <= 1'b0;
    end else begin
      FL_done <= w_next == DONE;
      if (r_state == IDLE) begin
        r_cnt <= '0;
        r_node <= 1'b0;
        r_nc <= nodeCount;
        r_v1 <= 1'b0;
        r_v2 <= 1'b0;
      end
      if (r_state == READ && rd_valid) r_data <= rd_data;
      if (r_state == CMP) begin
        r_m1 <= w_m1;
        r_m2 <= w_m2;
        r_id1 <= w_id1;
        r_id2 <= w_id2;
        r_v1 <= w_v1;
        r_v2 <= w_v2;
        r_node <= r_node | w_wrap;
        r_cnt <= w_wrap ? 8'd0 : r_cnt + 8'd1;
      end
      if (r_state != DONE && w_next == DONE) begin
        least1 <= w_v1 ? w_id1 : 9'h000;
        least2 <= w_v2 ? w_id2 : NO_ID;
        sum <= w_v2 ? w_m1 + w_m2 : '0;
      end
    end
endmodule

// File: tb/tb_t05_least_finder.sv
// tb_t05_least_finder: randomized scans against a selection-based reference model of the least finder
module tb_t05_least_finder;
  localparam int CH = 16;
  logic clk = 1'b0, rst_n = 1'b0, FL_en = 1'b0, rd_valid = 1'b0, rd_req, FL_done, ERROR;
  logic [6:0] nodeCount = '0;
  logic [45:0] rd_data = '0, sum;
  logic [8:0] rd_addr, least1, least2;
  logic [45:0] chr [CH];
  logic [45:0] nd [128];
  logic [8:0] seq [$];
  logic [8:0] e1, e2;
  logic [45:0] es;
  int ptr = 0, pct = 100, total = 0, passed = 0, fails = 0;
  bit chk_res = 1'b0;
  always #5 clk = ~clk;
  t05_least_finder #(.CHARS(CH)) dut (
    .clk(clk), .rst_n(rst_n), .FL_en(FL_en), .nodeCount(nodeCount),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .least1(least1), .least2(least2), .sum(sum), .FL_done(FL_done), .ERROR(ERROR)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end else passed++;
  endtask
  function automatic logic [45:0] val(input logic [8:0] a);
    if (a[8]) return nd[a[6:0]];
    return (a[7:0] < CH) ? chr[a[3:0]] : '0;
  endfunction
  // reference: scan list, then pick smallest and second smallest, earliest on ties
  task automatic model(input int nc);
    int b1, b2;
    b1 = -1;
    b2 = -1;
    seq = {};
    for (int i = 0; i < CH; i++) seq.push_back({1'b0, 8'(i)});
    for (int j = 0; j < nc; j++) seq.push_back({2'b10, 7'(j)});
    for (int i = 0; i < seq.size(); i++)
      if (val(seq[i]) != 0 && (b1 < 0 || val(seq[i]) < val(seq[b1]))) b1 = i;
    for (int i = 0; i < seq.size(); i++)
      if (i != b1 && val(seq[i]) != 0 && (b2 < 0 || val(seq[i]) < val(seq[b2]))) b2 = i;
    e1 = (b1 < 0) ? 9'h000 : seq[b1];
    e2 = (b2 < 0) ? 9'h180 : seq[b2];
    es = (b2 < 0) ? 46'd0 : val(seq[b1]) + val(seq[b2]);
  endtask
  always @(negedge clk) begin
    if (rd_req) begin
      if (ptr < seq.size()) chk("rd_addr", rd_addr, seq[ptr]);
      else chk("overread", ptr, seq.size());
      if ($urandom_range(1, 100) <= pct) begin
        rd_valid = 1'b1;
        rd_data = val(rd_addr);
        ptr++;
      end else begin
        rd_valid = 1'b0;
        rd_data = 46'({$urandom, $urandom});
      end
    end else begin
      rd_valid = 1'b0;
      rd_data = 46'({$urandom, $urandom});
    end
    if (FL_done && chk_res) begin
      chk("least1", least1, e1);
      chk("least2", least2, e2);
      chk("sum", sum, es);
    end
  end
  task automatic run_scan(input int nc, input int p, input int lat, input bit jitter);
    int n;
    nodeCount = 7'(nc);
    model(nc);
    ptr = 0;
    pct = p;
    chk_res = 1'b1;
    FL_en = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (jitter) nodeCount = 7'($urandom);
    end while (!FL_done && n < 3000);
    chk("done seen", FL_done, 1);
    if (lat >= 0) chk("latency", n, lat);
    chk("entries read", ptr, seq.size());
    chk("no error", ERROR, 0);
    repeat (3) @(negedge clk);
    FL_en = 1'b0;
    @(negedge clk);
    chk("done drop", FL_done, 0);
    chk("req drop", rd_req, 0);
    chk("least1 held", least1, e1);
    chk("sum held", sum, es);
    chk_res = 1'b0;
  endtask
  function automatic logic [45:0] rv(input int mode);
    case (mode)
      0: return 46'($urandom_range(0, 6));
      1: return ($urandom_range(0, 9) == 0) ? 46'($urandom_range(1, 50)) : 46'd0;
      2: return 46'({$urandom, $urandom});
      default: return 46'd0;
    endcase
  endfunction
  task automatic clear_mem();
    for (int i = 0; i < CH; i++) chr[i] = '0;
    for (int j = 0; j < 128; j++) nd[j] = '0;
  endtask
  task automatic reset_checks(input string tag);
    chk({tag, " rd_req"}, rd_req, 0);
    chk({tag, " rd_addr"}, rd_addr, 0);
    chk({tag, " least1"}, least1, 0);
    chk({tag, " least2"}, least2, 9'h180);
    chk({tag, " sum"}, sum, 0);
    chk({tag, " FL_done"}, FL_done, 0);
    chk({tag, " ERROR"}, ERROR, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, mode;
    clear_mem();
    repeat (2) @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chr[0] = 46'd5; chr[2] = 46'd3; chr[3] = 46'd7;
    run_scan(0, 100, 2 * CH, 0);
    chk("pin1 least1", e1, 9'h002); chk("pin1 least2", e2, 9'h000); chk("pin1 sum", es, 8);
    clear_mem();
    chr[0] = 46'd4; chr[1] = 46'd4; chr[2] = 46'd4; nd[0] = 46'd4;
    run_scan(1, 100, 2 * (CH + 1), 0);
    chk("pin2 least1", e1, 9'h000); chk("pin2 least2", e2, 9'h001); chk("pin2 sum", es, 8);
    clear_mem();
    chr[9] = 46'd12;
    run_scan(0, 60, -1, 1);
    chk("pin3 least1", e1, 9'h009); chk("pin3 least2", e2, 9'h180); chk("pin3 sum", es, 0);
    clear_mem();
    run_scan(3, 100, 2 * (CH + 3), 0);
    chk("pin4 least1", e1, 9'h000); chk("pin4 least2", e2, 9'h180); chk("pin4 sum", es, 0);
    nd[0] = 46'h3FFF_FFFF_FFFF; nd[1] = 46'h3FFF_FFFF_FFFF;
    run_scan(2, 100, 2 * (CH + 2), 0);
    chk("pin5 least1", e1, 9'h100); chk("pin5 least2", e2, 9'h101); chk("pin5 sum", es, 46'h3FFF_FFFF_FFFE);
    for (int i = 0; i < CH; i++) chr[i] = 46'($urandom_range(1, 99));
    nodeCount = '0;
    model(0);
    ptr = 0;
    pct = 100;
    FL_en = 1'b1;
    n = 0;
    while (!(rd_req && rd_addr == 9'h002) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach entry2", rd_addr, 9'h002);
    FL_en = 1'b0;
    @(negedge clk);
    chk("abort req", rd_req, 0);
    chk("abort done", FL_done, 0);
    chk("abort least1 kept", least1, 9'h100);
    chk("abort sum kept", sum, 46'h3FFF_FFFF_FFFE);
    @(negedge clk);
    run_scan(0, 100, 2 * CH, 0);
    model(0);
    ptr = 0;
    FL_en = 1'b1;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    reset_checks("midscan");
    FL_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    repeat (14) begin
      mode = $urandom_range(0, 3);
      for (int i = 0; i < CH; i++) chr[i] = rv(mode);
      for (int j = 0; j < 128; j++) nd[j] = rv(mode);
      if (mode == 3 && $urandom_range(0, 1) == 1) chr[$urandom_range(0, CH - 1)] = 46'($urandom_range(1, 9));
      run_scan($urandom_range(0, 12), $urandom_range(30, 100), -1, 1);
    end
`ifdef T05_FL_TIMEOUT_EN
    clear_mem();
    chr[0] = 46'd3;
    nodeCount = '0;
    model(0);
    ptr = 0;
    pct = 0;
    FL_en = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!FL_done && n < 400);
    chk("timeout latency", n, 255);
    chk("timeout ERROR", ERROR, 1);
    chk("timeout least1", least1, 9'h000);
    chk("timeout least2", least2, 9'h180);
    rst_n = 1'b0;
    #1;
    chk("timeout clr ERROR", ERROR, 0);
    chk("timeout clr done", FL_done, 0);
    FL_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
